// File: rtl/ssd_scan_controller_if.sv
// Load handshake and display-side signals of the seven-segment scanner.
// master drives value/handshake, slave is the scanner.
interface ssd_scan_controller_if #(
   parameter int NUM_DIGITS = 4
);
   logic                    enable;
   logic                    load_valid;
   logic                    load_ready;
   logic [4*NUM_DIGITS-1:0] load_value;
   logic                    lz_suppress;
   logic [3:0]              nibble_out;
   logic [NUM_DIGITS-1:0]   digit_en_n;
   logic                    blank;
   logic                    frame_done;

   modport master (
      output enable, load_valid, load_value, lz_suppress,
      input  load_ready, nibble_out, digit_en_n, blank, frame_done
   );

   modport slave (
      input  enable, load_valid, load_value, lz_suppress,
      output load_ready, nibble_out, digit_en_n, blank, frame_done
   );
endinterface

// File: rtl/ssd_scan_controller.sv
// Time-multiplexed seven-segment scan scheduler with a one-entry
// value buffer that only lands on frame boundaries.
module ssd_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   ssd_scan_controller_if.slave bus
);
   localparam int ND   = NUM_DIGITS;
   localparam int M1   = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
   localparam int MAXV = (M1 > 2) ? M1 : 2;
   localparam int DW   = $clog2(MAXV);
   localparam int IW   = $clog2(ND);
   localparam int GT   = (GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0;

   localparam logic [1:0] S_OFF   = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_GUARD = 2'd2;

   logic [1:0]      state;
   logic [IW-1:0]   digit;
   logic [DW-1:0]   div;
   logic [4*ND-1:0] active;
   logic [4*ND-1:0] pending;
   logic            pend_v;

   logic [3:0]      nib [ND];
   logic [ND-1:0]   supp;
   logic            zero;
   logic            drive_tc;
   logic            guard_tc;
   logic            last_digit;
   logic            boundary;
   logic            accept;
   logic [IW-1:0]   next_digit;

   assign drive_tc   = (state == S_DRIVE) && (div == DW'(REFRESH_DIV - 1));
   assign guard_tc   = (state == S_GUARD) && (div == DW'(GT));
   assign last_digit = (digit == IW'(ND - 1));
   assign next_digit = last_digit ? '0 : digit + IW'(1);
   assign accept     = bus.load_valid && !pend_v;
   assign boundary   = last_digit &&
                       ((GUARD_CYCLES == 0) ? drive_tc : guard_tc);

   // Leading-zero mask: digit i blanks when it and every higher nibble are 0.
   always_comb begin
      zero = 1'b1;
      supp = '0;
      for (int i = ND - 1; i >= 0; i--) begin
         nib[i]  = active[4*i +: 4];
         zero    = zero && (nib[i] == 4'h0);
         supp[i] = bus.lz_suppress && zero && (i != 0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_OFF;
         digit   <= '0;
         div     <= '0;
         active  <= '0;
         pending <= '0;
         pend_v  <= 1'b0;
      end else begin
         if (!bus.enable) begin
            state <= S_OFF;
            digit <= '0;
            div   <= '0;
         end else begin
            case (state)
               S_OFF: begin
                  state <= S_DRIVE;
                  digit <= '0;
                  div   <= '0;
               end
               S_DRIVE: begin
                  if (drive_tc) begin
                     div <= '0;
                     if (GUARD_CYCLES == 0) digit <= next_digit;
                     else state <= S_GUARD;
                  end else begin
                     div <= div + DW'(1);
                  end
               end
               S_GUARD: begin
                  if (guard_tc) begin
                     state <= S_DRIVE;
                     digit <= next_digit;
                     div   <= '0;
                  end else begin
                     div <= div + DW'(1);
                  end
               end
               default: begin
                  state <= S_OFF;
                  digit <= '0;
                  div   <= '0;
               end
            endcase
         end

         if (boundary && pend_v) begin
            active <= pending;
            pend_v <= 1'b0;
         end else if (accept) begin
            if ((state == S_OFF) || boundary) begin
               active <= bus.load_value;
            end else begin
               pending <= bus.load_value;
               pend_v  <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.digit_en_n = '1;
      bus.blank      = 1'b1;
      bus.nibble_out = (state == S_OFF) ? 4'h0 : nib[digit];
      if ((state == S_DRIVE) && !supp[digit]) begin
         bus.digit_en_n[digit] = 1'b0;
         bus.blank             = 1'b0;
      end
   end

   assign bus.frame_done = boundary;
   assign bus.load_ready = !pend_v;
endmodule
